// File: rtl/db_hash_table_pkg.sv
// Shared op codes, result flags, FSM states and entry sizing for the db_hash_table key/value store.
package db_hash_table_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [OP_W-1:0] {
    DB_OP_NOP    = 4'd0,
    DB_OP_LOOKUP = 4'd1,
    DB_OP_INSERT = 4'd2,
    DB_OP_DELETE = 4'd3
  } db_op_e;

  typedef enum logic [FLAG_W-1:0] {
    DB_RES_NONE     = 4'd0,
    DB_RES_HIT      = 4'd1,
    DB_RES_MISS     = 4'd2,
    DB_RES_INSERTED = 4'd3,
    DB_RES_UPDATED  = 4'd4,
    DB_RES_FULL     = 4'd5,
    DB_RES_DELETED  = 4'd6
  } db_res_e;

  // Status nibble carried inside the stored value by the filter logic.
  typedef enum logic [3:0] {
    DB_ST_NONE = 4'd0,
    SUSPECTION = 4'd1,
    ARREST     = 4'd2,
    FILTERED   = 4'd3,
    EXPIRED    = 4'd4
  } db_status_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_CMP
  } db_state_e;

  // Stored entry = valid bit + key + value (+ timestamp when aging is built in).
  function automatic int unsigned entry_w(input int unsigned key_w,
                                          input int unsigned val_w,
                                          input int unsigned time_w);
    return 1 + key_w + val_w + time_w;
  endfunction

endpackage

// File: rtl/db_hash_table_if.sv
// Request/response bus between the parser key stage and the db_hash_table store.
interface db_hash_table_if
  import db_hash_table_pkg::*;
#(
  parameter int unsigned KEY_SIZE = 96,
  parameter int unsigned VAL_SIZE = 32
);

  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     in_op;
  logic [KEY_SIZE-1:0] in_key;
  logic [VAL_SIZE-1:0] in_value;
  logic                out_valid;
  logic [FLAG_W-1:0]   out_flag;
  logic [VAL_SIZE-1:0] out_value;

  modport master (
    output in_valid, in_op, in_key, in_value,
    input  in_ready, out_valid, out_flag, out_value
  );

  modport slave (
    input  in_valid, in_op, in_key, in_value,
    output in_ready, out_valid, out_flag, out_value
  );

endinterface

// File: rtl/db_hash_table_way_ram.sv
// One way of the hash table: simple dual-port RAM with a registered (1-cycle) read.
module db_way_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 129
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/db_hash_table.sv
// Set-associative key/value store with XOR-folded index, post-reset clear sweep and per-way collision handling.
// Optional entry aging is built in when DB_AGING_EN is defined.
module db_hash_table
  import db_hash_table_pkg::*;
#(
  parameter int unsigned KEY_SIZE = 96,
  parameter int unsigned VAL_SIZE = 32,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned IDX_BITS = 10
`ifdef DB_AGING_EN
 ,parameter int unsigned TIME_BITS = 16,
  parameter int unsigned TICK_CYC  = 1000,
  parameter int unsigned TTL       = 600
`endif
) (
  input logic            clk,
  input logic            rst,
  db_hash_table_if.slave bus
);

`ifdef DB_AGING_EN
  localparam int unsigned STAMP_W = TIME_BITS;
`else
  localparam int unsigned STAMP_W = 0;
`endif
  localparam int unsigned ENTRY_W  = entry_w(KEY_SIZE, VAL_SIZE, STAMP_W);
  localparam int unsigned N_CHUNKS = (KEY_SIZE + IDX_BITS - 1) / IDX_BITS;
  localparam int unsigned PAD_W    = N_CHUNKS * IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic [KEY_SIZE-1:0] key;
    logic [VAL_SIZE-1:0] value;
`ifdef DB_AGING_EN
    logic [TIME_BITS-1:0] stamp;
`endif
  } entry_t;

  // Top chunk is zero-padded by the widening cast.
  function automatic logic [IDX_BITS-1:0] fold_idx(input logic [KEY_SIZE-1:0] key);
    logic [PAD_W-1:0]    padded;
    logic [IDX_BITS-1:0] idx;
    padded = PAD_W'(key);
    idx    = '0;
    for (int unsigned c = 0; c < N_CHUNKS; c++) idx = idx ^ padded[c*IDX_BITS +: IDX_BITS];
    return idx;
  endfunction

  db_state_e           state_q, state_d;
  logic [IDX_BITS-1:0] init_cnt_q, init_cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [FLAG_W-1:0]   out_flag_q, out_flag_d;
  logic [VAL_SIZE-1:0] out_value_q, out_value_d;
  logic [WAYS-1:0]     wr_oh_q, wr_oh_d;
  entry_t              wr_ent_q, wr_ent_d;

  db_op_e              op_q;
  logic [KEY_SIZE-1:0] key_q;
  logic [VAL_SIZE-1:0] val_q;
  logic [IDX_BITS-1:0] idx_q;

  logic                        start_c;
  logic [WAYS-1:0]             ram_we_c;
  logic [IDX_BITS-1:0]         ram_waddr_c;
  logic [ENTRY_W-1:0]          ram_wdata_c;
  logic [WAYS-1:0][ENTRY_W-1:0] rd_raw;

  logic [WAYS-1:0]     hit_c, free_c, inval_c;
  logic [VAL_SIZE-1:0] hit_val_c;
  entry_t              ent_c;

`ifdef DB_AGING_EN
  localparam int unsigned TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  logic [TICK_W-1:0]    tick_q;
  logic [TIME_BITS-1:0] now_q;
  logic [WAYS-1:0]      stale_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      now_q  <= '0;
    end else if (tick_q == TICK_W'(TICK_CYC - 1)) begin
      tick_q <= '0;
      now_q  <= now_q + TIME_BITS'(1);
    end else begin
      tick_q <= tick_q + TICK_W'(1);
    end
  end
`endif

  assign start_c = bus.in_valid && in_ready_q &&
                   (bus.in_op inside {DB_OP_LOOKUP, DB_OP_INSERT, DB_OP_DELETE});

  // The clear sweep owns the write port during INIT.
  assign ram_we_c    = (state_q == ST_INIT) ? '1         : wr_oh_q;
  assign ram_waddr_c = (state_q == ST_INIT) ? init_cnt_q : idx_q;
  assign ram_wdata_c = (state_q == ST_INIT) ? '0         : wr_ent_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    db_way_ram #(.ADDR_W(IDX_BITS), .DATA_W(ENTRY_W)) u_ram (
      .clk     (clk),
      .we_i    (ram_we_c[w]),
      .waddr_i (ram_waddr_c),
      .wdata_i (ram_wdata_c),
      .raddr_i (idx_q),
      .rdata_o (rd_raw[w])
    );
  end

  // Tag compare and free-way pick: invalid ways first, then expired ways, lowest index within each class.
  always_comb begin
    hit_c     = '0;
    free_c    = '0;
    inval_c   = '0;
    hit_val_c = '0;
    ent_c     = '0;
`ifdef DB_AGING_EN
    stale_c   = '0;
`endif
    for (int unsigned w = 0; w < WAYS; w++) begin
      ent_c      = entry_t'(rd_raw[w]);
      inval_c[w] = !ent_c.valid;
`ifdef DB_AGING_EN
      stale_c[w] = ent_c.valid && (TIME_BITS'(now_q - ent_c.stamp) >= TIME_BITS'(TTL));
      if (ent_c.valid && !stale_c[w] && (ent_c.key == key_q)) begin
`else
      if (ent_c.valid && (ent_c.key == key_q)) begin
`endif
        hit_c[w]  = 1'b1;
        hit_val_c = hit_val_c | ent_c.value;
      end
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      if ((free_c == '0) && inval_c[w]) free_c[w] = 1'b1;
    end
`ifdef DB_AGING_EN
    for (int unsigned w = 0; w < WAYS; w++) begin
      if ((free_c == '0) && stale_c[w]) free_c[w] = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    out_flag_d  = DB_RES_NONE;
    out_value_d = '0;
    wr_oh_d     = '0;
    wr_ent_d    = wr_ent_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + IDX_BITS'(1);
        if (init_cnt_q == '1) begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (start_c) begin
          state_d    = ST_RD;
          in_ready_d = 1'b0;
        end
      end
      ST_RD: state_d = ST_CMP;
      ST_CMP: begin
        state_d        = ST_IDLE;
        in_ready_d     = 1'b1;
        out_valid_d    = 1'b1;
        wr_ent_d.valid = 1'b1;
        wr_ent_d.key   = key_q;
        wr_ent_d.value = val_q;
`ifdef DB_AGING_EN
        wr_ent_d.stamp = now_q;
`endif
        case (op_q)
          DB_OP_LOOKUP: begin
            out_flag_d  = (|hit_c) ? DB_RES_HIT : DB_RES_MISS;
            out_value_d = hit_val_c;
          end
          DB_OP_INSERT: begin
            if (|hit_c) begin
              out_flag_d  = DB_RES_UPDATED;
              out_value_d = hit_val_c;
              wr_oh_d     = hit_c;
            end else if (|free_c) begin
              out_flag_d  = DB_RES_INSERTED;
              wr_oh_d     = free_c;
            end else begin
              out_flag_d  = DB_RES_FULL;
            end
          end
          DB_OP_DELETE: begin
            if (|hit_c) begin
              out_flag_d     = DB_RES_DELETED;
              out_value_d    = hit_val_c;
              wr_oh_d        = hit_c;
              wr_ent_d.valid = 1'b0;
            end else begin
              out_flag_d     = DB_RES_MISS;
            end
          end
          default: out_flag_d = DB_RES_MISS;
        endcase
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_flag_q  <= '0;
      out_value_q <= '0;
      wr_oh_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_flag_q  <= out_flag_d;
      out_value_q <= out_value_d;
      wr_oh_q     <= wr_oh_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_ent_q <= wr_ent_d;
    if (start_c) begin
      op_q  <= db_op_e'(bus.in_op);
      key_q <= bus.in_key;
      val_q <= bus.in_value;
      idx_q <= fold_idx(bus.in_key);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_flag  = out_flag_q;
  assign bus.out_value = out_value_q;

endmodule

// File: tb/tb_db_hash_table.sv
// Directed bench for db_hash_table (IDX_BITS=4, WAYS=2); the aging scenario runs when DB_AGING_EN is defined.
module tb_db_hash_table;
  import db_hash_table_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  db_hash_table_if #(.KEY_SIZE(96), .VAL_SIZE(32)) ifc ();

  db_hash_table #(
    .KEY_SIZE (96),
    .VAL_SIZE (32),
    .WAYS     (2),
    .IDX_BITS (4)
`ifdef DB_AGING_EN
   ,.TIME_BITS(16),
    .TICK_CYC (1),
    .TTL      (8)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse rst across one rising edge, then count INIT cycles until in_ready rises.
  task automatic do_reset(input string tag);
    int cyc;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_rdy0"}, 96'(ifc.in_ready), 96'd0);
    check({tag, "_ov0"}, 96'(ifc.out_valid), 96'd0);
    check({tag, "_flag0"}, 96'(ifc.out_flag), 96'd0);
    check({tag, "_val0"}, 96'(ifc.out_value), 96'd0);
    cyc = 0;
    while (ifc.in_ready !== 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_init_len"}, 96'(cyc), 96'd16);
  endtask

  // Issue one op from a falling edge; expect out_valid only in the cycle after E2.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [95:0] key,
                       input logic [31:0] val, input logic [3:0] exp_flag, input logic [31:0] exp_val);
    int         cyc;
    logic [2:0] ov;
    ifc.in_valid = 1'b1;
    ifc.in_op    = op;
    ifc.in_key   = key;
    ifc.in_value = val;
    cyc = 0;
    while (ifc.in_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ready"}, 96'(ifc.in_ready), 96'd1);
    @(posedge clk);
    @(negedge clk);
    ov[2] = ifc.out_valid;
    ifc.in_valid = 1'b0;
    ifc.in_op    = 4'd0;
    ifc.in_key   = '1;
    ifc.in_value = '1;
    @(negedge clk);
    ov[1] = ifc.out_valid;
    @(negedge clk);
    ov[0] = ifc.out_valid;
    check({tag, "_lat"}, 96'(ov), 96'b001);
    check({tag, "_flag"}, 96'(ifc.out_flag), 96'(exp_flag));
    check({tag, "_val"}, 96'(ifc.out_value), 96'(exp_val));
  endtask

  // A NOP or unknown code is consumed silently.
  task automatic nop_check(input string tag, input logic [3:0] op);
    logic seen;
    ifc.in_valid = 1'b1;
    ifc.in_op    = op;
    ifc.in_key   = 96'h11;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_op    = 4'd0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | ifc.out_valid;
    end
    check({tag, "_no_ov"}, 96'(seen), 96'd0);
    check({tag, "_ready"}, 96'(ifc.in_ready), 96'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst          = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_op    = 4'd0;
    ifc.in_key   = '0;
    ifc.in_value = '0;
    @(negedge clk);
    do_reset("por");
    do_op("lk_empty", DB_OP_LOOKUP, 96'h11, 32'h0, DB_RES_MISS, 32'h0);

`ifdef DB_AGING_EN
    do_op("ag_ins", DB_OP_INSERT, 96'h11, 32'h1, DB_RES_INSERTED, 32'h0);
    do_op("ag_lk_fresh", DB_OP_LOOKUP, 96'h11, 32'h0, DB_RES_HIT, 32'h1);
    repeat (20) @(negedge clk);
    do_op("ag_lk_old", DB_OP_LOOKUP, 96'h11, 32'h0, DB_RES_MISS, 32'h0);
    do_op("ag_del_old", DB_OP_DELETE, 96'h11, 32'h0, DB_RES_MISS, 32'h0);
    do_reset("ag_rst");
    do_op("ag_fill1", DB_OP_INSERT, 96'h11, 32'h1, DB_RES_INSERTED, 32'h0);
    do_op("ag_fill2", DB_OP_INSERT, 96'h22, 32'h2, DB_RES_INSERTED, 32'h0);
    do_op("ag_full", DB_OP_INSERT, 96'h33, 32'h3, DB_RES_FULL, 32'h0);
    repeat (20) @(negedge clk);
    do_op("ag_reuse", DB_OP_INSERT, 96'h33, 32'h3, DB_RES_INSERTED, 32'h0);
    do_op("ag_lk22", DB_OP_LOOKUP, 96'h22, 32'h0, DB_RES_MISS, 32'h0);
    do_op("ag_lk33", DB_OP_LOOKUP, 96'h33, 32'h0, DB_RES_HIT, 32'h3);
`else
    do_op("ins_a5", DB_OP_INSERT, 96'h11, 32'hA5, DB_RES_INSERTED, 32'h0);
    do_op("lk_a5", DB_OP_LOOKUP, 96'h11, 32'h0, DB_RES_HIT, 32'hA5);
    do_op("ins_far", DB_OP_INSERT, 96'hF00000000000000000000000, 32'hDEADBEEF, DB_RES_INSERTED, 32'h0);
    do_op("lk_far", DB_OP_LOOKUP, 96'hF00000000000000000000000, 32'h0, DB_RES_HIT, 32'hDEADBEEF);
    do_op("lk_tag", DB_OP_LOOKUP, 96'hF, 32'h0, DB_RES_MISS, 32'h0);
    nop_check("nop", 4'd0);
    nop_check("badop", 4'hF);

    do_reset("rst2");
    do_op("lk_cleared", DB_OP_LOOKUP, 96'h11, 32'h0, DB_RES_MISS, 32'h0);
    do_op("col_ins11", DB_OP_INSERT, 96'h11, 32'h1, DB_RES_INSERTED, 32'h0);
    do_op("col_ins22", DB_OP_INSERT, 96'h22, 32'h2, DB_RES_INSERTED, 32'h0);
    do_op("col_full33", DB_OP_INSERT, 96'h33, 32'h3, DB_RES_FULL, 32'h0);
    do_op("col_lk33", DB_OP_LOOKUP, 96'h33, 32'h0, DB_RES_MISS, 32'h0);

    do_op("upd22", DB_OP_INSERT, 96'h22, 32'h9, DB_RES_UPDATED, 32'h2);
    do_op("del11", DB_OP_DELETE, 96'h11, 32'h0, DB_RES_DELETED, 32'h1);
    do_op("reins33", DB_OP_INSERT, 96'h33, 32'h3, DB_RES_INSERTED, 32'h0);
    do_op("lk33", DB_OP_LOOKUP, 96'h33, 32'h0, DB_RES_HIT, 32'h3);
    do_op("lk22", DB_OP_LOOKUP, 96'h22, 32'h0, DB_RES_HIT, 32'h9);
    do_op("lk11_gone", DB_OP_LOOKUP, 96'h11, 32'h0, DB_RES_MISS, 32'h0);
    do_op("del11_miss", DB_OP_DELETE, 96'h11, 32'h0, DB_RES_MISS, 32'h0);
    do_op("full44", DB_OP_INSERT, 96'h44, 32'h4, DB_RES_FULL, 32'h0);

    // Abort an INSERT by raising rst while it sits in CMP.
    ifc.in_valid = 1'b1;
    ifc.in_op    = DB_OP_INSERT;
    ifc.in_key   = 96'h5;
    ifc.in_value = 32'h7;
    check("abort_ready", 96'(ifc.in_ready), 96'd1);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_op    = 4'd0;
    @(negedge clk);
    do_reset("abort");
    do_op("abort_lk5", DB_OP_LOOKUP, 96'h5, 32'h0, DB_RES_MISS, 32'h0);
    do_op("abort_lk33", DB_OP_LOOKUP, 96'h33, 32'h0, DB_RES_MISS, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
